// File: rtl/osnt_sume_rx_pkt_cutter.sv
// rtl/osnt_sume_rx_pkt_cutter.sv - RX packet truncation stage (optional OSNT_CUT_STATS_EN adds cut_pkt_count)
module osnt_sume_rx_pkt_cutter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 64,
    parameter int C_S_AXIS_DATA_WIDTH  = 64,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32
) (
    input  logic                              axis_aclk,
    input  logic                              axis_resetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    input  logic                              cut_en,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     cut_words,
    input  logic                              clear,
`ifdef OSNT_CUT_STATS_EN
    output logic [C_S_AXI_DATA_WIDTH-1:0]     cut_pkt_count,
`endif
    output logic [C_S_AXI_DATA_WIDTH-1:0]     rx_pkt_count
);

    typedef enum logic [1:0] {ST_HEAD, ST_PASS, ST_DROP} state_t;

    state_t      state;
    logic [15:0] bcnt;
    logic [15:0] snap_r;
    logic        cut_r;

    logic        head;
    logic        accept;
    logic [15:0] snap_new;
    logic        cut_new;
    logic [15:0] snap_cur;
    logic        cut_cur;
    logic [15:0] bcnt_cur;
    logic        end_cut;
    logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser_head;
    logic        unused_cut_words;

    assign unused_cut_words = ^cut_words[C_S_AXI_DATA_WIDTH-1:16];

    // The drop state never stalls upstream; otherwise the single output slice gates input.
    assign s_axis_tready = (state == ST_DROP) | ~m_axis_tvalid | m_axis_tready;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign head          = (state == ST_HEAD);

    // Snap length and cut decision are taken from config only on the first beat.
    assign snap_new = (cut_en && cut_words[15:0] != 16'd0) ? cut_words[15:0] : 16'd0;
    assign cut_new  = (snap_new != 16'd0) && ({3'b000, s_axis_tuser[15:0]} > {snap_new, 3'b000});
    assign snap_cur = head ? snap_new : snap_r;
    assign cut_cur  = head ? cut_new  : cut_r;
    assign bcnt_cur = head ? 16'd1 : ((bcnt == 16'hFFFF) ? bcnt : bcnt + 16'd1);
    assign end_cut  = cut_cur && !s_axis_tlast && (bcnt_cur == snap_cur);

    // First-beat metadata: rewritten length in [15:0], original length kept in [47:32].
    always_comb begin
        tuser_head        = s_axis_tuser;
        tuser_head[47:32] = s_axis_tuser[15:0];
        tuser_head[15:0]  = cut_new ? {snap_new[12:0], 3'b000} : s_axis_tuser[15:0];
    end

    // Packet FSM plus the registered output slice.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state         <= ST_HEAD;
            bcnt          <= 16'd0;
            snap_r        <= 16'd0;
            cut_r         <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready)
                m_axis_tvalid <= 1'b0;
            if (accept) begin
                if (state == ST_DROP) begin
                    if (s_axis_tlast)
                        state <= ST_HEAD;
                end else begin
                    snap_r        <= snap_cur;
                    cut_r         <= cut_cur;
                    bcnt          <= bcnt_cur;
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= s_axis_tdata;
                    m_axis_tkeep  <= end_cut ? {(C_M_AXIS_DATA_WIDTH/8){1'b1}} : s_axis_tkeep;
                    m_axis_tlast  <= s_axis_tlast | end_cut;
                    m_axis_tuser  <= head ? tuser_head : '0;
                    if (s_axis_tlast)
                        state <= ST_HEAD;
                    else if (end_cut)
                        state <= ST_DROP;
                    else
                        state <= ST_PASS;
                end
            end
        end
    end

    // Output packet counter; clear wins over increment.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn)
            rx_pkt_count <= '0;
        else if (clear)
            rx_pkt_count <= '0;
        else if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
            rx_pkt_count <= rx_pkt_count + 1'b1;
    end

`ifdef OSNT_CUT_STATS_EN
    // Truncated-packet counter, bumped on the first beat of each cut packet.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn)
            cut_pkt_count <= '0;
        else if (clear)
            cut_pkt_count <= '0;
        else if (accept && head && cut_new)
            cut_pkt_count <= cut_pkt_count + 1'b1;
    end
`endif

endmodule
